guess_grader: RTL

//  Stage directly downstream of loadMasterPattern.
//  - Snapshots the 12-bit master pattern once masterLoaded asserts.
//  - Accepts up to MAX_ROUNDS player guesses.
//  - Grades each guess sequentially, reporting Znarly (right shape, right slot)
//    and Zood (right shape, wrong slot).
//  - Tracks rounds and declares a win or loss; feeds the round/score display logic.

---
 rtl/guess_grader_pkg.sv | 28 ++
 rtl/guess_grader_shape_counter.sv | 22 ++
 rtl/guess_grader.sv | 137 +++++++++++++
 3 files changed

// File: rtl/guess_grader_pkg.sv
// -----------------------------------------------------------------------------
// guess_grader_pkg
//   Shared types for the guess grader: shape codes, four-slot patterns, the
//   grader FSM state enum and a small min() helper used by the scorer.
// -----------------------------------------------------------------------------
package guess_grader_pkg;

  localparam int NUM_SLOTS = 4;

  typedef logic [2:0] shape_t;

  // Slot 3 occupies [11:9] down to slot 0 at [2:0].
  typedef shape_t [NUM_SLOTS-1:0] pattern_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_GUESS,
    ST_SCORE,
    ST_REPORT,
    ST_WON,
    ST_LOST
  } grader_state_t;

  function automatic logic [2:0] min3(input logic [2:0] a, input logic [2:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/guess_grader_shape_counter.sv
// -----------------------------------------------------------------------------
// shape_counter
//   Counts how many slots of a pattern hold a given shape code.
//   i_pattern : pattern_t  four 3-bit shapes
//   i_s       : shape_t    shape code to count
//   o_count   : [2:0]      number of matching slots (0..4)
// -----------------------------------------------------------------------------
module shape_counter
  import guess_grader_pkg::*;
(
  input  pattern_t   i_pattern,
  input  shape_t     i_s,
  output logic [2:0] o_count
);

  always_comb begin
    o_count = '0;
    for (int i = 0; i < NUM_SLOTS; i++)
      o_count = o_count + {2'b00, (i_pattern[i] == i_s)};
  end

endmodule

// File: rtl/guess_grader.sv
// -----------------------------------------------------------------------------
// guess_grader
//   Snapshots the master pattern, grades up to MAX_ROUNDS guesses and reports
//   exact (Znarly) and shape-only (Zood) matches, round count and win/loss.
//   clock, reset (async, active high)
//   startGame      : synchronous restart to IDLE, highest priority
//   masterPattern  : [11:0] master, captured once when masterLoaded in IDLE
//   masterLoaded   : master valid
//   Guess          : [11:0] player guess, captured on GradeIt rising edge
//   GradeIt        : grade request (rising edge used)
//   Znarly, Zood   : [3:0] score of last graded guess
//   RoundNumber    : [3:0] guesses graded this game
//   scoreValid     : one-cycle pulse when the score outputs update
//   GameWon        : high in WON
//   GameOver       : high in WON or LOST
// -----------------------------------------------------------------------------
module guess_grader
  import guess_grader_pkg::*;
#(
  parameter int MAX_ROUNDS = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        startGame,
  input  logic [11:0] masterPattern,
  input  logic        masterLoaded,
  input  logic [11:0] Guess,
  input  logic        GradeIt,
  output logic [3:0]  Znarly,
  output logic [3:0]  Zood,
  output logic [3:0]  RoundNumber,
  output logic        scoreValid,
  output logic        GameWon,
  output logic        GameOver
);

  localparam logic [3:0] MAXR = 4'(MAX_ROUNDS);

  grader_state_t r_state, w_next;
  pattern_t      r_master, r_guess;
  shape_t        r_s;
  logic [2:0]    r_acc, r_exact;
  logic          r_grade_q;

  logic          w_grade_edge;
  logic [2:0]    w_cnt_m, w_cnt_g, w_exact;

  assign w_grade_edge = GradeIt & ~r_grade_q;

  shape_counter u_cnt_master (.i_pattern(r_master), .i_s(r_s), .o_count(w_cnt_m));
  shape_counter u_cnt_guess  (.i_pattern(r_guess),  .i_s(r_s), .o_count(w_cnt_g));

  always_comb begin
    w_exact = '0;
    for (int i = 0; i < NUM_SLOTS; i++)
      w_exact = w_exact + {2'b00, (r_master[i] == r_guess[i])};
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (startGame) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:       if (masterLoaded) w_next = ST_WAIT_GUESS;
        ST_WAIT_GUESS: if (w_grade_edge) w_next = ST_SCORE;
        ST_SCORE:      if (r_s == 3'd7)  w_next = ST_REPORT;
        ST_REPORT: begin
          if (r_exact == 3'd4)                w_next = ST_WON;
          else if (RoundNumber + 4'd1 == MAXR) w_next = ST_LOST;
          else                                 w_next = ST_WAIT_GUESS;
        end
        ST_WON:        w_next = ST_WON;
        ST_LOST:       w_next = ST_LOST;
        default:       w_next = ST_IDLE;
      endcase
    end
  end

  assign GameWon  = (r_state == ST_WON);
  assign GameOver = (r_state == ST_WON) || (r_state == ST_LOST);

  // ---------------- datapath ----------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_master    <= '0;
      r_guess     <= '0;
      r_s         <= '0;
      r_acc       <= '0;
      r_exact     <= '0;
      r_grade_q   <= 1'b0;
      Znarly      <= '0;
      Zood        <= '0;
      RoundNumber <= '0;
      scoreValid  <= 1'b0;
    end else begin
      r_grade_q  <= GradeIt;
      scoreValid <= 1'b0;
      if (startGame) begin
        Znarly      <= '0;
        Zood        <= '0;
        RoundNumber <= '0;
      end else begin
        case (r_state)
          ST_IDLE:
            if (masterLoaded) r_master <= masterPattern;
          ST_WAIT_GUESS:
            if (w_grade_edge) begin
              r_guess <= Guess;
              r_s     <= '0;
              r_acc   <= '0;
            end
          ST_SCORE: begin
            // One shape code per cycle; r_s wraps back to 0 after code 7.
            r_acc   <= r_acc + min3(w_cnt_m, w_cnt_g);
            r_s     <= r_s + 3'd1;
            r_exact <= w_exact;
          end
          ST_REPORT: begin
            Znarly     <= {1'b0, r_exact};
            Zood       <= {1'b0, r_acc - r_exact};
            if (RoundNumber != MAXR) RoundNumber <= RoundNumber + 4'd1;
            scoreValid <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
